pipeline_stall_controller: RTL and testbench

- Central stall/flush arbiter for the 5-stage pipelined RISC-V core.
- Consumes hazard requests (load-use bubble, EX-stage branch mispredict, I/D-cache not-ready, ECALL halt) and drives per-stage pipeline-register write enables and flushes.
- Sequences multi-cycle data-cache stalls and the end-of-program drain.
- Counts stall and flush cycles for performance reporting.

---
 rtl/pipeline_stall_controller_pkg.sv | 16 +
 rtl/pipeline_stall_controller_perf_counter.sv | 20 ++
 rtl/pipeline_stall_controller.sv | 156 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the core
// pipeline stages it drives.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } stall_state_t;

  localparam int unsigned HALT_REG = 17;
  localparam int unsigned HALT_VAL = 10;
  localparam logic [31:0] NOP      = 32'h00000013;

endpackage

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Free-running performance counter with synchronous clear and count enable;
// wraps modulo 2^CNT_W.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush arbiter for the 5-stage core: turns hazard requests into
// per-stage write enables and flushes, sequences D-cache stalls and halt drain.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             ex_mispredict,
  input  logic             icache_ready,
  input  logic             dcache_req,
  input  logic             dcache_ready,
  input  logic             halt_id,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_wb_flush,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  stall_state_t  state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_d;
  logic          dstall;
  logic          flush_take;
  logic          stall_en;

  assign dstall = dcache_req && !dcache_ready;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    halted_d     = is_halted;
    flush_take   = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    mem_wb_flush = 1'b0;

    unique case (state_q)
      RUN, DSTALL: begin
        if ((state_q == RUN && dstall) || (state_q == DSTALL && !dcache_ready)) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          mem_wb_flush = 1'b1;
          state_d      = DSTALL;
        end else begin
          // The DSTALL release cycle reuses the full RUN chain: everything
          // advances this cycle, so a halt in ID must be accepted here too.
          state_d = RUN;
          if (ex_mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_take  = 1'b1;
          end else if (load_use_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (halt_id) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = DRAIN;
            drain_d     = DW'(DRAIN_CYCLES - 1);
          end else if (!icache_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        if (dstall) begin
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
          mem_wb_flush = 1'b1;
        end else if (drain_q == '0) begin
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      HALTED: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (reset) begin
      flush_take   = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      mem_wb_flush = 1'b0;
    end
  end

  assign stall_en = !reset && (state_q == RUN || state_q == DSTALL) && !pc_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      drain_q   <= '0;
      is_halted <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      is_halted <= halted_d;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (stall_en),
    .count (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (flush_take),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller with hand-computed
// stage-control words and counter values.
module tb_pipeline_stall_controller;

  localparam int unsigned W = 4;

  // Control word order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, memwb_f
  localparam logic [7:0] C_RUN    = 8'b1101_0110;
  localparam logic [7:0] C_LU     = 8'b0001_1110;
  localparam logic [7:0] C_MISP   = 8'b1111_1110;
  localparam logic [7:0] C_FRZ    = 8'b0000_0001;
  localparam logic [7:0] C_HOLDIF = 8'b0111_0110;
  localparam logic [7:0] C_DRSTL  = 8'b0110_0001;
  localparam logic [7:0] C_HALTED = 8'b0000_0000;

  logic clk = 1'b0;
  logic reset, load_use_stall, ex_mispredict, icache_ready;
  logic dcache_req, dcache_ready, halt_id;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_write, mem_wb_flush, is_halted;
  logic [W-1:0] stall_cycles, flush_count;
  logic [7:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, mem_wb_write, mem_wb_flush};

  pipeline_stall_controller #(.DRAIN_CYCLES(4), .CNT_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_use_stall (load_use_stall),
    .ex_mispredict  (ex_mispredict),
    .icache_ready   (icache_ready),
    .dcache_req     (dcache_req),
    .dcache_ready   (dcache_ready),
    .halt_id        (halt_id),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_write    (id_ex_write),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_write   (ex_mem_write),
    .mem_wb_write   (mem_wb_write),
    .mem_wb_flush   (mem_wb_flush),
    .is_halted      (is_halted),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    load_use_stall = 1'b0;
    ex_mispredict  = 1'b0;
    icache_ready   = 1'b1;
    dcache_req     = 1'b0;
    dcache_ready   = 1'b1;
    halt_id        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    mid();
    check("reset_ctl", ctl, C_RUN);
    repeat (3) tick();
    reset = 1'b0;
    mid();
    check("idle_ctl", ctl, C_RUN);
    check("idle_stall", stall_cycles, 0);
    check("idle_flush", flush_count, 0);
    check("idle_halted", is_halted, 0);

    // load-use bubble
    tick();
    load_use_stall = 1'b1;
    mid();
    check("lu_ctl", ctl, C_LU);
    tick();
    idle();
    check("lu_stall", stall_cycles, 1);
    mid();
    check("lu_after_ctl", ctl, C_RUN);

    // mispredict wins over load-use
    tick();
    ex_mispredict  = 1'b1;
    load_use_stall = 1'b1;
    mid();
    check("misp_ctl", ctl, C_MISP);
    tick();
    idle();
    check("misp_flush", flush_count, 1);
    check("misp_stall", stall_cycles, 1);

    // 5-cycle data-cache stall
    dcache_req   = 1'b1;
    dcache_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      check($sformatf("dstall_ctl%0d", i), ctl, C_FRZ);
      tick();
    end
    dcache_ready = 1'b1;
    mid();
    check("dstall_rel_ctl", ctl, C_RUN);
    tick();
    check("dstall_stall", stall_cycles, 6);
    dcache_req   = 1'b0;
    dcache_ready = 1'b0;
    mid();
    check("dstall_back_run", ctl, C_RUN);
    tick();

    // mispredict in the DSTALL release cycle
    dcache_req   = 1'b1;
    dcache_ready = 1'b0;
    mid();
    check("dsm_frz", ctl, C_FRZ);
    tick();
    dcache_ready  = 1'b1;
    ex_mispredict = 1'b1;
    mid();
    check("dsm_ctl", ctl, C_MISP);
    tick();
    idle();
    check("dsm_flush", flush_count, 2);
    check("dsm_stall", stall_cycles, 7);

    // I-cache miss
    icache_ready = 1'b0;
    mid();
    check("icm_ctl", ctl, C_HOLDIF);
    tick();
    idle();
    check("icm_stall", stall_cycles, 8);

    // halt without cache stalls
    halt_id = 1'b1;
    mid();
    check("halt_acc_ctl", ctl, C_HOLDIF);
    tick();
    halt_id = 1'b0;
    check("halt_stall", stall_cycles, 9);
    for (int i = 1; i <= 4; i++) begin
      mid();
      check($sformatf("drain_ctl%0d", i), ctl, C_HOLDIF);
      check($sformatf("drain_halted%0d", i), is_halted, 0);
      tick();
    end
    check("halted_rise", is_halted, 1);
    ex_mispredict  = 1'b1;
    load_use_stall = 1'b1;
    icache_ready   = 1'b0;
    mid();
    check("halted_ctl", ctl, C_HALTED);
    tick();
    tick();
    idle();
    check("halted_hold", is_halted, 1);
    check("halted_stall_frozen", stall_cycles, 9);
    check("halted_flush_frozen", flush_count, 2);

    // halt with a 2-cycle data-cache stall during drain
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_stall", stall_cycles, 0);
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      dcache_req   = (i <= 2);
      dcache_ready = !(i <= 2);
      mid();
      check($sformatf("dd_ctl%0d", i), ctl, (i <= 2) ? C_DRSTL : C_HOLDIF);
      check($sformatf("dd_halted%0d", i), is_halted, 0);
      tick();
    end
    idle();
    check("dd_halted_rise", is_halted, 1);
    check("dd_stall", stall_cycles, 1);

    // reset during drain
    reset = 1'b1;
    tick();
    reset = 1'b0;
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    tick();
    reset = 1'b1;
    mid();
    check("rd_reset_ctl", ctl, C_RUN);
    tick();
    reset = 1'b0;
    check("rd_halted", is_halted, 0);
    check("rd_stall", stall_cycles, 0);
    check("rd_flush", flush_count, 0);
    mid();
    check("rd_run_ctl", ctl, C_RUN);
    repeat (5) tick();
    check("rd_no_halt", is_halted, 0);

    // counter wrap at 2^W
    icache_ready = 1'b0;
    repeat (15) tick();
    check("wrap_15", stall_cycles, 15);
    repeat (2) tick();
    check("wrap_17", stall_cycles, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
